// File: rtl/shift_pkg.sv
// Shared definitions for the shift-register family: mode encoding and sizing helpers.
package shift_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_HOLD = 3'b000;
  localparam mode_t MODE_SHR  = 3'b001;
  localparam mode_t MODE_SHL  = 3'b010;
  localparam mode_t MODE_ROR  = 3'b011;
  localparam mode_t MODE_ROL  = 3'b100;
  localparam mode_t MODE_LOAD = 3'b101;
  localparam mode_t MODE_CLR  = 3'b110;
  localparam mode_t MODE_ASR  = 3'b111;

  // Modes that move data by one lane and therefore advance the word counter.
  function automatic logic is_shift(input mode_t m);
    return (m == MODE_SHR) || (m == MODE_SHL) || (m == MODE_ROR) ||
           (m == MODE_ROL) || (m == MODE_ASR);
  endfunction

  // Counter width for a modulus of m; a modulus of one still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-M event counter with a registered one-cycle wrap pulse.
module mod_counter
  import shift_pkg::*;
#(
  parameter  int unsigned M  = 8,
  localparam int unsigned CW = cnt_width(M)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          wrap
);

  logic [CW-1:0] r_count;
  logic          r_wrap;
  logic [CW-1:0] w_count_next;
  logic          w_wrap_next;
  logic          w_at_last;

  assign w_at_last = (r_count == CW'(M - 1));

  // clr dominates inc; the wrap pulse is cleared on any cycle without a wrapping inc.
  always_comb begin
    w_count_next = r_count;
    w_wrap_next  = 1'b0;
    if (clr) begin
      w_count_next = '0;
    end else if (inc) begin
      w_wrap_next  = w_at_last;
      w_count_next = w_at_last ? '0 : r_count + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_wrap  <= w_wrap_next;
    end
  end

  assign count = r_count;
  assign wrap  = r_wrap;

endmodule

// File: rtl/universal_shift_register.sv
// N-bit universal shift register with S-bit serial lanes and a word-complete counter.
module universal_shift_register
  import shift_pkg::*;
#(
  parameter  int unsigned N  = 8,
  parameter  int unsigned S  = 1,
  localparam int unsigned M  = N / S,
  localparam int unsigned CW = cnt_width(M)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  mode_t         mode,
  input  logic [S-1:0]  SI_R,
  input  logic [S-1:0]  SI_L,
  input  logic [N-1:0]  I,
  output logic [N-1:0]  Q,
  output logic [S-1:0]  SO_R,
  output logic [S-1:0]  SO_L,
  output logic [CW-1:0] cnt,
  output logic          word_done
);

  if ((N < 2) || (S < 1) || (S >= N) || ((N % S) != 0)) begin : g_param_check
    $error("universal_shift_register: need N >= 2, 1 <= S < N and N %% S == 0");
  end

  logic [N-1:0] r_q;
  logic [N-1:0] w_q_next;
  logic         w_inc;
  logic         w_clr;

  // Next data word; en=0 or HOLD leaves the register untouched.
  always_comb begin
    w_q_next = r_q;
    if (en) begin
      case (mode)
        MODE_SHR:  w_q_next = {SI_R, r_q[N-1:S]};
        MODE_SHL:  w_q_next = {r_q[N-S-1:0], SI_L};
        MODE_ROR:  w_q_next = {r_q[S-1:0], r_q[N-1:S]};
        MODE_ROL:  w_q_next = {r_q[N-S-1:0], r_q[N-1:N-S]};
        MODE_LOAD: w_q_next = I;
        MODE_CLR:  w_q_next = '0;
        MODE_ASR:  w_q_next = {{S{r_q[N-1]}}, r_q[N-1:S]};
        default:   w_q_next = r_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= '0;
    end else begin
      r_q <= w_q_next;
    end
  end

  // Load/clear restart the word; every enabled shift advances it regardless of direction.
  assign w_inc = en && is_shift(mode);
  assign w_clr = en && ((mode == MODE_LOAD) || (mode == MODE_CLR));

  mod_counter #(
    .M (M)
  ) u_mod_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (w_inc),
    .clr     (w_clr),
    .count   (cnt),
    .wrap    (word_done)
  );

  assign Q    = r_q;
  assign SO_R = r_q[S-1:0];
  assign SO_L = r_q[N-1:N-S];

endmodule
